// File: rtl/alu_z_stage.sv
// Result-capture stage behind the combinational ALU: settle wait for MUL/DIV, 2-entry result queue.
// Optional architectural LO/HI registers are built when ZSTAGE_HILO_EN is defined.
module alu_z_stage #(
    parameter int LONG_WAIT = 4
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic [4:0]  op_in,
    input  logic [31:0] z_lo_in,
    input  logic [31:0] z_hi_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_lo,
    output logic [31:0] out_hi,
    output logic [4:0]  out_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] lo_reg,
    output logic [31:0] hi_reg
);

    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [3:0] CNT_LOAD = 4'(LONG_WAIT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  op;
    } entry_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;
    entry_t      entry_vec [2];
    entry_t      push_entry;
    entry_t      head;
    logic        is_long;
    logic        full;
    logic        push;
    logic        pop;

    assign is_long = (op_in == OP_MUL) || (op_in == OP_DIV);
    assign full    = (count_reg == 2'd2);

    // in_ready looks only at registered full, so a pop never frees a slot in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready = !is_long && !full;
            ST_WAIT: in_ready = (cnt_reg == 4'd0) && !full;
            default: in_ready = 1'b0;
        endcase
        if (!clear_n) begin
            in_ready = 1'b0;
        end
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && is_long) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    // Upstream dropping in_valid before the handshake abandons the op.
                    if (!in_valid) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= 4'd0;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (!full) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 4'd0;
                end
            endcase
        end
    end

    // Only long ops (captured from the WAIT state) carry a meaningful high word.
    always_comb begin
        push_entry.lo = z_lo_in;
        push_entry.hi = (state_reg == ST_WAIT) ? z_hi_in : 32'h0;
        push_entry.op = op_in;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            entry_t entry_reg;

            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_entry;
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head      = entry_vec[rd_ptr_reg];
    assign out_lo    = head.lo;
    assign out_hi    = head.hi;
    assign out_op    = head.op;
    assign out_valid = (count_reg != 2'd0);

`ifdef ZSTAGE_HILO_EN
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            lo_reg <= 32'h0;
            hi_reg <= 32'h0;
        end else if (push && (state_reg == ST_WAIT)) begin
            lo_reg <= z_lo_in;
            hi_reg <= z_hi_in;
        end
    end
`else
    assign lo_reg = 32'h0;
    assign hi_reg = 32'h0;
`endif

endmodule

// File: tb/tb_alu_z_stage.sv
// Scoreboard bench for alu_z_stage: directed timing scenarios followed by randomized traffic.
module tb_alu_z_stage;

    localparam int LW = 4;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    logic        clock = 1'b0;
    logic        clear_n;
    logic [4:0]  op_in;
    logic [31:0] z_lo_in;
    logic [31:0] z_hi_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_lo;
    logic [31:0] out_hi;
    logic [4:0]  out_op;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] lo_reg;
    logic [31:0] hi_reg;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  op;
    } exp_t;

    exp_t        expq [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_lo = 32'h0;
    logic [31:0] m_hi = 32'h0;
    int          ready_mode = 0;

    bit          prev_hold = 1'b0;
    logic [31:0] prev_lo;
    logic [31:0] prev_hi;
    logic [4:0]  prev_op;

    alu_z_stage #(.LONG_WAIT(LW)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .op_in     (op_in),
        .z_lo_in   (z_lo_in),
        .z_hi_in   (z_hi_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_lo    (out_lo),
        .out_hi    (out_hi),
        .out_op    (out_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lo_reg    (lo_reg),
        .hi_reg    (hi_reg)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp_v, $time);
        end
    endtask

    function automatic bit is_long(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Consumer side: out_ready follows ready_mode (0 low, 1 high, 2 random).
    always @(posedge clock) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Issue one op and hold it until the handshake; waited = cycles with in_ready low.
    task automatic send(input logic [4:0] op, input logic [31:0] lo, input logic [31:0] hi,
                        output int waited);
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        op_in    = op;
        z_lo_in  = lo;
        z_hi_in  = hi;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                check("send_timeout", 32'(waited), 32'(0));
                in_valid = 1'b0;
                step();
                return;
            end
            step();
        end
        e.lo = lo;
        e.hi = is_long(op) ? hi : 32'h0;
        e.op = op;
        expq.push_back(e);
        $display("issue op=%b lo=%h hi=%h waited=%0d", op, lo, hi, waited);
        step();
`ifdef ZSTAGE_HILO_EN
        if (is_long(op)) begin
            m_lo = lo;
            m_hi = hi;
        end
`endif
        in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every accepted output and checks hold stability.
    always @(negedge clock) begin
        exp_t e;
        if (!clear_n || !out_valid) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_lo", out_lo, prev_lo);
                check("hold_hi", out_hi, prev_hi);
                check("hold_op", 32'(out_op), 32'(prev_op));
            end
            if (out_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'(0));
                end else begin
                    e = expq.pop_front();
                    $display("pop op=%b lo=%h hi=%h exp_lo=%h exp_hi=%h", out_op, out_lo, out_hi, e.lo, e.hi);
                    check("pop_lo", out_lo, e.lo);
                    check("pop_hi", out_hi, e.hi);
                    check("pop_op", 32'(out_op), 32'(e.op));
                end
            end
            prev_hold = !out_ready;
            prev_lo   = out_lo;
            prev_hi   = out_hi;
            prev_op   = out_op;
        end
    end

    always @(negedge clock) begin
        if (clear_n) begin
            check("lo_reg", lo_reg, m_lo);
            check("hi_reg", hi_reg, m_hi);
        end
    end

    initial begin
        int w;
        logic [4:0] op;
        clear_n  = 1'b0;
        in_valid = 1'b1;
        op_in    = OP_ADD;
        z_lo_in  = 32'h1234;
        z_hi_in  = 32'h5678;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_lo", out_lo, 32'h0);
        check("rst_out_hi", out_hi, 32'h0);
        check("rst_out_op", 32'(out_op), 32'(0));
        check("rst_lo_reg", lo_reg, 32'h0);
        check("rst_hi_reg", hi_reg, 32'h0);
        in_valid = 1'b0;
        clear_n  = 1'b1;
        step();

        // Short-op latency and hi forcing.
        ready_mode = 1;
        send(OP_ADD, 32'h5, 32'hFFFF_FFFF, w);
        check("short_wait", 32'(w), 32'(0));
        @(negedge clock);
        check("short_valid", 32'(out_valid), 32'(1));
        check("short_lo", out_lo, 32'h5);
        check("short_hi", out_hi, 32'h0);
        check("short_op", 32'(out_op), 32'(OP_ADD));
        step();
        step();

        // MUL settle time.
        ready_mode = 0;
        send(OP_MUL, 32'h10, 32'h1, w);
        check("mul_wait", 32'(w), 32'(LW));
        @(negedge clock);
        check("mul_valid", 32'(out_valid), 32'(1));
        check("mul_lo", out_lo, 32'h10);
        check("mul_hi", out_hi, 32'h1);
`ifdef ZSTAGE_HILO_EN
        check("mul_hi_reg", hi_reg, 32'h1);
        check("mul_lo_reg", lo_reg, 32'h10);
`else
        check("mul_hi_reg_off", hi_reg, 32'h0);
`endif
        step();
        ready_mode = 1;
        step();
        step();

        // Full queue: third push must be held until a slot frees.
        ready_mode = 0;
        send(OP_ADD, 32'h1, $urandom, w);
        send(OP_ADD, 32'h2, $urandom, w);
        check("fill2_wait", 32'(w), 32'(0));
        in_valid = 1'b1;
        op_in    = OP_ADD;
        z_lo_in  = 32'h3;
        z_hi_in  = 32'hABCD;
        repeat (3) begin
            @(negedge clock);
            check("full_in_ready", 32'(in_ready), 32'(0));
            step();
        end
        ready_mode = 1;
        @(negedge clock);
        check("full_pop_in_ready", 32'(in_ready), 32'(0));
        step();
        send(OP_ADD, 32'h3, 32'hABCD, w);
        check("after_full_wait", 32'(w), 32'(0));
        repeat (4) step();
        check("full_drained", 32'(expq.size()), 32'(0));

        // Simultaneous push and pop with one entry held.
        ready_mode = 0;
        send(OP_ADD, 32'h55, 32'h0, w);
        ready_mode = 1;
        send(OP_SUB, 32'h7, 32'h99, w);
        check("pp_wait", 32'(w), 32'(0));
        ready_mode = 0;
        @(negedge clock);
        check("pp_valid", 32'(out_valid), 32'(1));
        check("pp_head_lo", out_lo, 32'h7);
        check("pp_head_op", 32'(out_op), 32'(OP_SUB));
        step();
        ready_mode = 1;
        step();
        step();

        // DIV abort after two cycles.
        ready_mode = 0;
        in_valid = 1'b1;
        op_in    = OP_DIV;
        z_lo_in  = $urandom;
        z_hi_in  = $urandom;
        repeat (2) begin
            @(negedge clock);
            check("div_in_ready", 32'(in_ready), 32'(0));
            step();
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("abort_out_valid", 32'(out_valid), 32'(0));
            step();
        end
        send(OP_ADD, 32'h9, 32'h0, w);
        check("abort_add_wait", 32'(w), 32'(0));
        @(negedge clock);
        check("abort_add_valid", 32'(out_valid), 32'(1));
        check("abort_add_lo", out_lo, 32'h9);
        step();
        ready_mode = 1;
        step();
        step();

        // Asynchronous reset in WAIT with cnt at 2.
        ready_mode = 0;
        send(OP_ADD, 32'h11, 32'h0, w);
        in_valid = 1'b1;
        op_in    = OP_DIV;
        z_lo_in  = 32'hDEAD;
        z_hi_in  = 32'hBEEF;
        step();
        step();
        #1;
        clear_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_in_ready", 32'(in_ready), 32'(0));
        check("arst_out_lo", out_lo, 32'h0);
        check("arst_lo_reg", lo_reg, 32'h0);
        check("arst_hi_reg", hi_reg, 32'h0);
        expq.delete();
        m_lo = 32'h0;
        m_hi = 32'h0;
        in_valid = 1'b0;
        step();
        clear_n = 1'b1;
        send(OP_ADD, 32'h22, 32'h0, w);
        check("post_rst_wait", 32'(w), 32'(0));
        @(negedge clock);
        check("post_rst_valid", 32'(out_valid), 32'(1));
        check("post_rst_lo", out_lo, 32'h22);
        step();

        // Randomized traffic against the scoreboard.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            end else begin
                op = 5'($urandom_range(0, 31));
            end
            send(op, $urandom, $urandom, w);
            if ($urandom_range(0, 2) == 0) step();
        end

        ready_mode = 1;
        for (int i = 0; i < 20 && expq.size() != 0; i++) step();
        step();
        check("final_queue_empty", 32'(expq.size()), 32'(0));
        @(negedge clock);
        check("final_out_valid", 32'(out_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
